pong_input_conditioner: RTL and testbench
=========================================

Name: pong_input_conditioner

Overview:
- Upstream front end for the Mono Pong game core.
- Takes the four raw Zybo push-buttons (start, stop, left paddle, right paddle), synchronises and debounces each one, and produces clean levels and single-cycle press pulses.
- Converts each paddle button into a time-limited "swing" strobe that ends after a fixed window even if the button is held. This stops a player winning by holding a paddle down.
- Outputs feed the game core's start, stop, push_1 and push_2 inputs and the blue paddle LEDs.

Parameters:
- DEBOUNCE_CYCLES, 1250000: consecutive stable synchronised cycles needed to accept a level change (10 ms at 125 MHz); legal range 1..2^31-1.
- SWING_CYCLES, 25000000: maximum cycles a paddle swing stays high per press (0.2 s); legal range 1..2^31-1.

Ports:
- clk  input  1  Zybo 125 MHz clock.
- rst_n  input  1  Reset, asynchronous, active-low.
- start  input  1  Raw start button, active-high, asynchronous to clk.
- stop  input  1  Raw stop button.
- push_1  input  1  Raw left paddle button.
- push_2  input  1  Raw right paddle button.
- start_db  output  1  Debounced start level.
- stop_db  output  1  Debounced stop level.
- start_pulse  output  1  One-cycle strobe on start_db rising.
- stop_pulse  output  1  One-cycle strobe on stop_db rising.
- swing_l  output  1  Left paddle swing, window-limited.
- swing_r  output  1  Right paddle swing, window-limited.
- lock_l  output  1  High while the left paddle is held past its swing window.
- lock_r  output  1  High while the right paddle is held past its swing window.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low, on ports clk and rst_n.
  - Asserting rst_n low immediately clears all synchroniser flops, debounced levels, counters and outputs to 0.
  - Both swing FSMs go to READY.
- Synchroniser, per button: two flops, giving synchronised signal s.
  - Raw input high before edge k gives s=1 after edge k+1.
- Debouncer, per button: registered level db with a 31-bit counter cnt.
  - Each edge: if s==db, cnt<=0.
  - Else if cnt==DEBOUNCE_CYCLES-1, db<=s and cnt<=0.
  - Else cnt<=cnt+1.
  - Latency: a raw edge before clock edge k, held stable, gives db changed after edge k+1+DEBOUNCE_CYCLES.
  - Any excursion shorter than DEBOUNCE_CYCLES synchronised cycles leaves db unchanged and restarts the count.
  - Rising and falling edges are debounced identically.
- start_db and stop_db are the db levels directly.
- start_pulse and stop_pulse are high for exactly the one cycle in which db has just become 1 (registered on the same edge db rises). No pulse is generated on a falling edge.
- Swing FSM, per paddle, with a 31-bit counter scnt.
  - READY: swing=0, lock=0. If db==1, go to SWING with swing<=1 and scnt<=0. Swing therefore rises one edge after db rises.
  - SWING: if db==0, go to READY with swing<=0. Else if scnt==SWING_CYCLES-1, go to LOCKED with swing<=0 and lock<=1. Else scnt<=scnt+1.
    - A held button therefore gives swing high for exactly SWING_CYCLES cycles.
    - A tap shorter than SWING_CYCLES gives swing high for the same number of cycles db was high.
  - LOCKED: swing=0, lock=1. If db==0, go to READY with lock<=0.
    - A new swing needs a debounced release, then a debounced press.
  - Release coinciding with timeout (db==0 on the edge where scnt==SWING_CYCLES-1): the release wins and the FSM goes to READY; lock never asserts.
- Left and right paddles are fully independent. Simultaneous presses produce simultaneous swings. No cross-inhibit is applied.
- Button held through reset: treated as a fresh press after reset release.
  - db rises after 2+DEBOUNCE_CYCLES edges (sync refill plus debounce).
  - The paddle then swings normally; start and stop pulse normally.
- Reset asserted mid-swing or mid-lock: swing and lock drop asynchronously; no residual state survives.
- The game core samples on its slow clock. It uses swing_l/swing_r and the stop_db/start_db levels, not the one-cycle pulses. The pulses are for fast-clock consumers only.

Test Plan:
- Bench parameters: DEBOUNCE_CYCLES=4, SWING_CYCLES=6. Edge numbers are clock edges.
1. Reset with push_1=1, start=1 and rst_n low → every output 0 while rst_n=0. After release at edge 0: start_db=1 and swing_l=1 appear after edges 6 and 7 respectively.
2. start rises before edge 10 and is held → start_db=1 after edge 15. start_pulse=1 for exactly cycle 15→16. start falls before edge 30 → start_db=0 after edge 35, no pulse.
3. push_2 high for 3 cycles, low, then high for 3 cycles → stays glitch-free: swing_r, lock_r and the debounced level remain 0 throughout.
4. push_1 high before edge 10, held 20 cycles → swing_l high after edges 16..21 (6 cycles). lock_l=1 from edge 22 until release debounce completes (db falls after edge 35), then lock_l=0 after edge 36.
5. push_2 tap of 4 cycles before edge 10 → db high edges 15..18. swing_r high after edges 16..19 (4 cycles). lock_r never asserts.
6. Hold push_1, pull rst_n low while swing_l=1 → swing_l=0 immediately. After release at edge 0 with the button still held → swing_l rises after edge 7 and lasts 6 cycles.

Source files
------------

// File: rtl/pong_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module : pong_input_conditioner
// Brief  : Sync/debounce of the four Zybo buttons, start/stop press pulses and
//          window-limited paddle swing strobes for the Mono Pong core.
// Rev    : 1.0
// ============================================================================
module pong_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1250000,
  parameter int unsigned SWING_CYCLES    = 25000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic stop,
  input  logic push_1,
  input  logic push_2,
  output logic start_db,
  output logic stop_db,
  output logic start_pulse,
  output logic stop_pulse,
  output logic swing_l,
  output logic swing_r,
  output logic lock_l,
  output logic lock_r
);

  localparam int unsigned c_NBTN     = 4;
  localparam logic [30:0] c_DB_LAST  = 31'(DEBOUNCE_CYCLES - 1);
  localparam logic [30:0] c_SW_LAST  = 31'(SWING_CYCLES - 1);

  typedef enum logic [1:0] {
    S_READY  = 2'd0,
    S_SWING  = 2'd1,
    S_LOCKED = 2'd2
  } swing_state_e;

  logic [c_NBTN-1:0] raw_w;
  logic [c_NBTN-1:0] db_lvl;
  logic [c_NBTN-1:0] db_nxt;
  logic [1:0]        pulse_q;
  logic [1:0]        swing_w;
  logic [1:0]        lock_w;

  assign raw_w = {push_2, push_1, stop, start};

  genvar gi;
  generate
    for (gi = 0; gi < c_NBTN; gi++) begin : g_btn
      logic        sync1_q;
      logic        sync2_q;
      logic        db_q;
      logic        db_d;
      logic [30:0] cnt_q;
      logic [30:0] cnt_d;

      // Counter only advances while the synchronised input disagrees with db.
      always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q + 31'd1;
        if (sync2_q == db_q) begin
          cnt_d = '0;
        end else if (cnt_q == c_DB_LAST) begin
          db_d  = sync2_q;
          cnt_d = '0;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync1_q <= 1'b0;
          sync2_q <= 1'b0;
          db_q    <= 1'b0;
          cnt_q   <= '0;
        end else begin
          sync1_q <= raw_w[gi];
          sync2_q <= sync1_q;
          db_q    <= db_d;
          cnt_q   <= cnt_d;
        end
      end

      assign db_lvl[gi] = db_q;
      assign db_nxt[gi] = db_d;
    end
  endgenerate

  // Pulse registers on the same edge db rises, so it coincides with db's first high cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_q <= 2'b00;
    end else begin
      pulse_q <= db_nxt[1:0] & ~db_lvl[1:0];
    end
  end

  genvar gp;
  generate
    for (gp = 0; gp < 2; gp++) begin : g_paddle
      swing_state_e state_q;
      swing_state_e state_d;
      logic [30:0]  scnt_q;
      logic [30:0]  scnt_d;
      logic         swing_q;
      logic         swing_d;
      logic         lock_q;
      logic         lock_d;
      logic         pdb;

      assign pdb = db_lvl[2+gp];

      always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        swing_d = swing_q;
        lock_d  = lock_q;
        case (state_q)
          S_READY: begin
            if (pdb) begin
              state_d = S_SWING;
              swing_d = 1'b1;
              scnt_d  = '0;
            end
          end
          S_SWING: begin
            // A release on the timeout edge returns to READY without locking.
            if (!pdb) begin
              state_d = S_READY;
              swing_d = 1'b0;
            end else if (scnt_q == c_SW_LAST) begin
              state_d = S_LOCKED;
              swing_d = 1'b0;
              lock_d  = 1'b1;
            end else begin
              scnt_d = scnt_q + 31'd1;
            end
          end
          S_LOCKED: begin
            if (!pdb) begin
              state_d = S_READY;
              lock_d  = 1'b0;
            end
          end
          default: begin
            state_d = S_READY;
            swing_d = 1'b0;
            lock_d  = 1'b0;
          end
        endcase
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_q <= S_READY;
          scnt_q  <= '0;
          swing_q <= 1'b0;
          lock_q  <= 1'b0;
        end else begin
          state_q <= state_d;
          scnt_q  <= scnt_d;
          swing_q <= swing_d;
          lock_q  <= lock_d;
        end
      end

      assign swing_w[gp] = swing_q;
      assign lock_w[gp]  = lock_q;
    end
  endgenerate

  assign start_db    = db_lvl[0];
  assign stop_db     = db_lvl[1];
  assign start_pulse = pulse_q[0];
  assign stop_pulse  = pulse_q[1];
  assign swing_l     = swing_w[0];
  assign swing_r     = swing_w[1];
  assign lock_l      = lock_w[0];
  assign lock_r      = lock_w[1];

endmodule
`default_nettype wire

// File: tb/tb_pong_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module : tb_pong_input_conditioner
// Brief  : Randomised bench for pong_input_conditioner against a history-based
//          reference model. Rev 1.0
// ============================================================================
module tb_pong_input_conditioner;

  localparam int D    = 4;
  localparam int SW   = 6;
  localparam int MAXC = 4096;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn   = 4'b0000;
  logic start_db, stop_db, start_pulse, stop_pulse;
  logic swing_l, swing_r, lock_l, lock_r;

  int n_checks = 0;
  int n_errors = 0;
  int t        = 0;
  int hold [4];
  int rise_e [2];
  bit raw_h [4][MAXC];
  bit s_h   [4][MAXC];
  bit db_h  [4][MAXC];
  bit exp_sw [2];
  bit exp_lk [2];
  bit exp_pl [2];

  always #5 clk = ~clk;

  pong_input_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .SWING_CYCLES   (SW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (btn[0]),
    .stop       (btn[1]),
    .push_1     (btn[2]),
    .push_2     (btn[3]),
    .start_db   (start_db),
    .stop_db    (stop_db),
    .start_pulse(start_pulse),
    .stop_pulse (stop_pulse),
    .swing_l    (swing_l),
    .swing_r    (swing_r),
    .lock_l     (lock_l),
    .lock_r     (lock_r)
  );

  task automatic check_eq(input string tag, input logic obs, input logic exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0d got=%b expected=%b", tag, t, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_start_db"},    start_db,    1'b0);
    check_eq({tag, "_stop_db"},     stop_db,     1'b0);
    check_eq({tag, "_start_pulse"}, start_pulse, 1'b0);
    check_eq({tag, "_stop_pulse"},  stop_pulse,  1'b0);
    check_eq({tag, "_swing_l"},     swing_l,     1'b0);
    check_eq({tag, "_swing_r"},     swing_r,     1'b0);
    check_eq({tag, "_lock_l"},      lock_l,      1'b0);
    check_eq({tag, "_lock_r"},      lock_r,      1'b0);
  endtask

  // Edge 0 is the reset release point; edge 1 is the first clock afterwards.
  task automatic model_reset();
    t = 0;
    for (int b = 0; b < 4; b++) begin
      raw_h[b][0] = 1'b0;
      s_h[b][0]   = 1'b0;
      db_h[b][0]  = 1'b0;
    end
    for (int p = 0; p < 2; p++) begin
      rise_e[p] = -MAXC;
      exp_sw[p] = 1'b0;
      exp_lk[p] = 1'b0;
      exp_pl[p] = 1'b0;
    end
  endtask

  // db flips once the last D synchronised samples all disagree with it;
  // a paddle swings for at most SW cycles of each continuous debounced press.
  task automatic model_edge();
    bit prev;
    bit flip;
    int age;
    for (int b = 0; b < 4; b++) begin
      raw_h[b][t] = btn[b];
      s_h[b][t]   = (t >= 2) ? raw_h[b][t-1] : 1'b0;
      prev        = db_h[b][t-1];
      flip        = (t >= D);
      for (int k = 1; k <= D; k++) begin
        if (t - k < 0) flip = 1'b0;
        else if (s_h[b][t-k] == prev) flip = 1'b0;
      end
      db_h[b][t] = flip ? ~prev : prev;
    end
    for (int p = 0; p < 2; p++) begin
      age       = (t - 1) - rise_e[p];
      exp_sw[p] = db_h[2+p][t-1] && (age < SW);
      exp_lk[p] = db_h[2+p][t-1] && (age >= SW);
      if (db_h[2+p][t] && !db_h[2+p][t-1]) rise_e[p] = t;
      exp_pl[p] = db_h[p][t] && !db_h[p][t-1];
    end
  endtask

  task automatic step();
    @(posedge clk);
    t++;
    if (t >= MAXC) begin
      $display("FAIL cycle_bound t=%0d limit=%0d", t, MAXC);
      $fatal(1, "cycle bound exceeded");
    end
    model_edge();
    #1;
    check_eq("start_db",    start_db,    db_h[0][t]);
    check_eq("stop_db",     stop_db,     db_h[1][t]);
    check_eq("start_pulse", start_pulse, exp_pl[0]);
    check_eq("stop_pulse",  stop_pulse,  exp_pl[1]);
    check_eq("swing_l",     swing_l,     exp_sw[0]);
    check_eq("swing_r",     swing_r,     exp_sw[1]);
    check_eq("lock_l",      lock_l,      exp_lk[0]);
    check_eq("lock_r",      lock_r,      exp_lk[1]);
    #1;
  endtask

  task automatic rand_drive();
    for (int b = 0; b < 4; b++) begin
      if (hold[b] == 0) begin
        btn[b]  = ~btn[b];
        hold[b] = ($urandom_range(0, 4) == 0) ? int'($urandom_range(15, 30))
                                              : int'($urandom_range(1, 14));
      end else begin
        hold[b]--;
      end
    end
  endtask

  task automatic apply_reset(input logic [3:0] held);
    #2;
    rst_n = 1'b0;
    btn   = held;
    #1;
    check_all_zero("rst_async");
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    bit found;
    model_reset();

    // Buttons held through reset act as fresh presses afterwards.
    apply_reset(4'b0101);
    repeat (30) step();
    btn = 4'b0000;
    repeat (20) step();

    // Short bursts on the right paddle must never get through.
    btn[3] = 1'b1; repeat (3) step();
    btn[3] = 1'b0; step();
    btn[3] = 1'b1; repeat (3) step();
    btn[3] = 1'b0; repeat (10) step();

    // Exact 4-cycle tap on the right paddle.
    btn[3] = 1'b1; repeat (4) step();
    btn[3] = 1'b0; repeat (15) step();

    for (int b = 0; b < 4; b++) hold[b] = 0;
    repeat (1500) begin
      step();
      rand_drive();
    end
    btn = 4'b0000;
    repeat (20) step();

    // Reset in the middle of a left swing.
    btn[2] = 1'b1;
    found  = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (exp_sw[0]) found = 1'b1;
    end
    check_eq("swing_l_reached", found, 1'b1);
    apply_reset(4'b0100);
    repeat (30) step();
    btn = 4'b0000;
    repeat (20) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
